// File: rtl/approx_pp_accumulator.sv
// Sequential shift-add multiplier whose low APPROX_COLS columns merge by OR.
// Define APPROX_PP_ZERO_SKIP_EN to finish early once the remaining multiplier bits are zero.
module approx_pp_accumulator #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Ones over the OR-reduced columns; empty when APPROX_COLS is 0.
  localparam logic [PW-1:0] LOW_MASK =
    {PW{1'b1}} >> (PW - APPROX_COLS);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [PW-1:0] a_ext;
  logic [PW-1:0] row;
  logic [PW-1:0] hi_sum;
  logic [PW-1:0] acc_nx;
  logic          last_row;

  assign a_ext  = {{WIDTH{1'b0}}, a_q};
  assign row    = b_q[0] ? (a_ext << cnt_q) : '0;

  // Low field is masked out of both addends, so no carry crosses into it.
  assign hi_sum = (acc_q & ~LOW_MASK) + (row & ~LOW_MASK);
  assign acc_nx = (hi_sum & ~LOW_MASK)
                | ((acc_q | row) & LOW_MASK);

`ifdef APPROX_PP_ZERO_SKIP_EN
  assign last_row = (b_q >> 1) == '0;
`else
  assign last_row = cnt_q == CW'(WIDTH - 1);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_nx;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (last_row) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign product   = acc_q;

endmodule

// File: tb/tb_approx_pp_accumulator.sv
// Randomized and directed bench for approx_pp_accumulator.
// Runs an APPROX_COLS=4 and an exact (APPROX_COLS=0) instance in lock-step.
module tb_approx_pp_accumulator;

  localparam int W  = 8;
  localparam int AC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_ready;

  logic          in_ready,  in_ready0;
  logic          out_valid, out_valid0;
  logic [2*W-1:0] product,  product0;
  logic          busy,      busy0;

  int n_cmp = 0;
  int n_err = 0;
  int overlap_err = 0;

  always #5 clk = ~clk;

  approx_pp_accumulator #(.WIDTH(W), .APPROX_COLS(AC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  approx_pp_accumulator #(.WIDTH(W), .APPROX_COLS(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
    .product(product0), .busy(busy0)
  );

  always @(negedge clk) begin
    if (in_ready && busy) overlap_err++;
  end

  // Sum of rows above the cut, OR of rows below it.
  function automatic logic [15:0] model(int unsigned av, int unsigned bv, int cols);
    longint unsigned lo = 0, hi = 0, row;
    for (int i = 0; i < W; i++) begin
      row = ((bv >> i) & 1) != 0 ? (longint'(av) << i) : 0;
      lo |= row & ((64'd1 << cols) - 1);
      hi += row >> cols;
    end
    return 16'(((hi << cols) | lo) & 64'hFFFF);
  endfunction

  function automatic int exp_lat(int unsigned bv);
`ifdef APPROX_PP_ZERO_SKIP_EN
    int n = 1;
    for (int i = 0; i < W; i++) if (((bv >> i) & 1) != 0) n = i + 1;
    return n;
`else
    return W;
`endif
  endfunction

  // Accept one operand pair, then count edges until out_valid (bounded).
  task automatic run_op(input int unsigned av, input int unsigned bv, output int lat);
    int g = 0;
    while (!in_ready && g < 40) begin
      @(posedge clk); #1; g++;
    end
    a = W'(av); b = W'(bv); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, busy, product} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      n_err++;
      $display("FAIL reset: rdy/vld/busy/prod=%b%b%b/%h want 100/0000",
               in_ready, out_valid, busy, product);
    end
  endtask

  task automatic test_vectors;
    int unsigned va[$] = '{15, 255, 255, 0, 77, 0};
    int unsigned vb[$] = '{15, 255, 1, 99, 0, 0};
    int lat;
    logic [15:0] e;
    for (int i = 0; i < 30; i++) begin
      va.push_back($urandom_range(0, 255));
      vb.push_back($urandom_range(0, 255));
    end
    out_ready = 1'b1;
    foreach (va[i]) begin
      run_op(va[i], vb[i], lat);
      e = model(va[i], vb[i], AC);
      n_cmp++;
      if (product !== e || !out_valid) begin
        n_err++;
        $display("FAIL approx a=%0d b=%0d: got %h vld=%b want %h", va[i], vb[i], product, out_valid, e);
      end
      n_cmp++;
      if (product0 !== 16'(va[i] * vb[i]) || !out_valid0) begin
        n_err++;
        $display("FAIL exact a=%0d b=%0d: got %h want %h", va[i], vb[i], product0, 16'(va[i] * vb[i]));
      end
      n_cmp++;
      if (lat !== exp_lat(vb[i])) begin
        n_err++;
        $display("FAIL latency b=%0d: got %0d want %0d", vb[i], lat, exp_lat(vb[i]));
      end
    end
    n_cmp++;
    if (model(15, 15, AC) !== 16'd191) begin
      n_err++;
      $display("FAIL model_15x15: got %0d want 191", model(15, 15, AC));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int lat;
    logic [15:0] held;
    out_ready = 1'b0;
    run_op(170, 85, lat);
    held = product;
    n_cmp++;
    if (held !== model(170, 85, AC)) begin
      n_err++;
      $display("FAIL bp_value: got %h want %h", held, model(170, 85, AC));
    end
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (!out_valid || product !== held || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold %0d: vld=%b prod=%h rdy=%b want 1/%h/0",
                 i, out_valid, product, in_ready, held);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_err++;
      $display("FAIL bp_release: vld/rdy/busy=%b%b%b want 010", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_rst_mid;
    int lat;
    logic seen = 1'b0;
    out_ready = 1'b1;
    a = 8'd200; b = 8'd100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, busy, product} !== {3'b010, 16'h0}) begin
      n_err++;
      $display("FAIL rst_mid: vld/rdy/busy/prod=%b%b%b/%h want 010/0000",
               out_valid, in_ready, busy, product);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_pulse: got out_valid=1 want 0");
    end
    run_op(3, 5, lat);
    n_cmp++;
    if (product !== 16'd15) begin
      n_err++;
      $display("FAIL after_rst 3x5: got %0d want 15", product);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int unsigned a1 = $urandom_range(0, 255), b1 = $urandom_range(0, 255);
    int unsigned a2 = $urandom_range(0, 255), b2 = $urandom_range(0, 255);
    int lat = 0;
    out_ready = 1'b1;
    overlap_err = 0;
    a = W'(a1); b = W'(b1); in_valid = 1'b1;
    @(posedge clk); #1;
    a = W'(a2); b = W'(b2);
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    n_cmp++;
    if (product !== model(a1, b1, AC) || lat !== exp_lat(b1)) begin
      n_err++;
      $display("FAIL b2b_first: got %h lat %0d want %h lat %0d",
               product, lat, model(a1, b1, AC), exp_lat(b1));
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b_idle: vld/rdy=%b%b want 01", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if ({busy, in_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_accept: busy/rdy=%b%b want 10", busy, in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    n_cmp++;
    if (product !== model(a2, b2, AC) || product0 !== 16'(a2 * b2)) begin
      n_err++;
      $display("FAIL b2b_second: got %h/%h want %h/%h",
               product, product0, model(a2, b2, AC), 16'(a2 * b2));
    end
    @(posedge clk); #1;
    n_cmp++;
    if (overlap_err !== 0) begin
      n_err++;
      $display("FAIL overlap: got %0d in_ready&&busy cycles want 0", overlap_err);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_rst_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/approx_pp_accumulator.md
Name: approx_pp_accumulator

Overview:
- Iterative approximate multiplier front end. Generates one partial-product row per cycle and reduces it into an accumulator.
- The low APPROX_COLS columns are reduced carry-only (bitwise OR, no sum, no carry-out). The upper columns use an exact add.
- This is the producer-side counterpart of the carry-only compressor cells: a sequential generate-and-reduce path for area-constrained multiplier experiments.
- Valid/ready handshake on both the operand and result sides.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.
- APPROX_COLS, 4, number of low product columns reduced by OR; 0 gives an exact multiplier; legal range 0..2*WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands a, b are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  approximate product.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst). All state updates on the rising edge of clk.
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, accumulator=0, row counter=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - on in_valid&&in_ready, latch a into a_reg and b into b_sh; clear accumulator and counter; go to RUN.
- RUN (one edge per row i, i=0..WIDTH-1):
  - row = b_sh[0] ? (a_reg << i) : 0, zero-extended to 2*WIDTH.
  - acc[APPROX_COLS-1:0] <= acc_low | row_low.
  - acc[2W-1:APPROX_COLS] <= acc_high + row_high, modulo 2^(2W-APPROX_COLS). No carry from the low field into the high field.
  - b_sh >>= 1; counter++.
  - On the edge processing row WIDTH-1, go to DONE.
- DONE:
  - out_valid=1; product=acc, held stable until accepted.
  - on out_ready, go to IDLE; out_valid deasserts on that edge.
  - in_ready=0 in RUN and DONE, so there is no overlap of operations.
- Latency: out_valid rises exactly WIDTH edges after the accept edge. Throughput is one result per WIDTH+2 cycles with out_ready held high.
- Backpressure: out_ready low holds DONE indefinitely; product and out_valid do not change.
- in_valid without in_ready (RUN/DONE): ignored, no side effects.
- rst mid-operation: returns to the reset state on that edge; the partial result is discarded; no out_valid pulse.
- APPROX_COLS=0: result equals the exact a*b.
- APPROX_COLS=2*WIDTH: result is the OR of all rows.
- b=0 or a=0: all rows are zero; product=0; same latency as any other operand pair.

Optional Feature:
- Macro: APPROX_PP_ZERO_SKIP_EN.
- With the macro defined: in RUN, if (b_sh>>1)==0 after the current row, go to DONE on that edge. Rows processed = max(1, index of MSB set in b + 1), and out_valid rises that many edges after accept. Product value is unchanged, because skipped rows are zero.
- Without the macro: always exactly WIDTH rows; fixed latency.

Test Plan:
- WIDTH=8, APPROX_COLS=4, a=15, b=15 -> product=191 (0x00BF); exact 225. out_valid rises 8 edges after accept.
- WIDTH=8, APPROX_COLS=0, a=255, b=255 -> product=65025 (0xFE01), exact.
- WIDTH=8, APPROX_COLS=4, a=255, b=1 -> product=255. Latency 8 edges without the macro; 1 edge with APPROX_PP_ZERO_SKIP_EN.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> product and out_valid stable for all 5 cycles. in_ready=0 and in_valid pulses are ignored. On out_ready=1, IDLE follows the next edge.
- rst asserted at row 3 of a=200, b=100 -> next cycle IDLE, out_valid=0, in_ready=1. A following a=3, b=5 yields product=15 (APPROX_COLS=4: rows 3 and 12, low OR=15, high=0).
- Back-to-back: two operations with out_ready=1 -> second accept occurs the cycle after first out_valid handshake. in_ready never high while busy=1.
